pattern_sequencer: RTL and testbench
====================================

Name: pattern_sequencer

Overview:
- Selects which monitor-test pattern generator drives the VGA colour outputs, and owns the shared RGB output path.
- Sits between the pattern generators (screensaver, colour bars, etc., each producing 12-bit RGB from x/y) and the VGA timing/output stage.
- Takes debounced user buttons and commits pattern changes only at frame boundaries, so no frame ever shows a torn mix of two patterns.
- Registers and blanks the muxed RGB.

Parameters:
- NUM_PATTERNS, 4, number of pattern inputs (2..16).
- DEBOUNCE_CYCLES, 250000, consecutive stable cycles before a button level is accepted (10 ms at 25 MHz).
- AUTO_FRAMES, 300, frames per pattern in auto-cycle mode (used only with the optional feature).
- H_ACTIVE, 640, visible pixels per line.
- V_ACTIVE, 480, visible lines per frame.

Ports:
- clock25MHz  in  1  pixel clock; the only clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- x  in  10  current pixel column from the VGA timing block.
- y  in  10  current pixel row from the VGA timing block.
- frame_start  in  1  one-cycle pulse at the start of each frame, outside the active area.
- btn_next  in  1  raw button, active-high, asynchronous to the clock.
- btn_prev  in  1  raw button, active-high, asynchronous to the clock.
- btn_mode  in  1  raw button, active-high; toggles auto mode (see Optional Feature).
- pat_rgb  in  12*NUM_PATTERNS  flattened pattern outputs; slice k is {r[3:0],g[3:0],b[3:0]} of pattern k at bits [12k+11:12k].
- red  out  4  registered colour output.
- green  out  4  registered colour output.
- blue  out  4  registered colour output.
- pattern_sel  out  $clog2(NUM_PATTERNS)  committed pattern index.
- switch_pending  out  1  a request is waiting for the next frame_start.
- auto_mode  out  1  auto-cycle mode is active.

Behaviour:
- Reset (asynchronous assert, synchronous release): pattern_sel=0; red/green/blue=0; switch_pending=0; auto_mode=0; FSM=IDLE; synchronizers, debounced levels and counters=0.
- Button path, per button:
  - 2-flop synchronizer, then debounce counter.
  - The counter resets whenever the synchronized level differs from the debounced level.
  - When the counter reaches DEBOUNCE_CYCLES-1 with the level still different, the debounced level takes the new value.
  - A debounced rising edge gives a one-cycle press pulse. Input-to-pulse latency is 2+DEBOUNCE_CYCLES cycles.
- FSM states: IDLE, PENDING.
  - IDLE: a next or prev press loads the direction register and moves to PENDING; switch_pending=1.
  - PENDING: another press overwrites the direction (latest wins). At frame_start, pattern_sel is updated and the FSM returns to IDLE; switch_pending=0 in the following cycle.
- Simultaneous next and prev presses in the same cycle cancel each other: no state change.
- A press in the same cycle as frame_start is not committed on that frame; it is held for the next frame_start.
- Wrap-around, mod NUM_PATTERNS:
  - next from NUM_PATTERNS-1 goes to 0.
  - prev from 0 goes to NUM_PATTERNS-1.
- Output datapath, 1-cycle latency from x/y/pat_rgb:
  - When x<H_ACTIVE and y<V_ACTIVE, {red,green,blue} <= slice[pattern_sel].
  - Otherwise {red,green,blue} <= 0.
- pattern_sel is only ever updated on a frame_start cycle, never mid-frame.
- Reset asserted mid-frame forces outputs to 0 immediately and discards any pending request.

Optional Feature:
- Macro: PATTERN_SEQUENCER_AUTO_CYCLE_EN.
- Defined:
  - btn_mode has its own debounce path; each press toggles auto_mode.
  - A frame counter counts frame_start pulses while auto_mode=1. At the frame_start where the count equals AUTO_FRAMES-1, pattern_sel advances as "next" and the counter clears.
  - A manual request committed at a frame_start takes priority over the auto advance and clears the counter.
  - Leaving auto mode clears the counter.
- Undefined:
  - btn_mode is ignored and auto_mode is tied to 0.
  - No frame counter logic exists.

Test Plan:
- Release reset, drive all patterns with distinct constants (k -> 12'h111*(k+1)), x=10, y=10 -> pattern_sel=0 and RGB=4'h1 on each channel one cycle later. At x=700 -> RGB=0.
- Hold btn_next high for DEBOUNCE_CYCLES+5 mid-frame -> switch_pending=1. pattern_sel changes 0->1 only on the next frame_start; output becomes 4'h2 one cycle after that.
- Apply 3 glitches on btn_next, each shorter than DEBOUNCE_CYCLES -> no press pulse; pattern_sel unchanged across 2 frames.
- pattern_sel=0, valid btn_prev press -> after frame_start, pattern_sel=NUM_PATTERNS-1 (3). A press landing on the frame_start cycle commits on the following frame only.
- Press next then prev within one frame -> pattern_sel moves by -1 (latest wins). Next and prev pulses forced in the same cycle -> no change, switch_pending stays 0.
- With PATTERN_SEQUENCER_AUTO_CYCLE_EN and AUTO_FRAMES=3: press btn_mode -> auto_mode=1, pattern_sel advances every 3rd frame_start. Assert reset mid-frame -> auto_mode=0, pattern_sel=0, RGB=0 immediately.

Source files
------------

// File: rtl/pattern_sequencer.sv
// Frame-synchronous test-pattern selector: debounced next/prev buttons, commit on frame_start,
// registered and blanked RGB output. Define PATTERN_SEQUENCER_AUTO_CYCLE_EN for auto-cycle mode.
module pattern_sequencer #(
    parameter int NUM_PATTERNS    = 4,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int AUTO_FRAMES     = 300,
    parameter int H_ACTIVE        = 640,
    parameter int V_ACTIVE        = 480
) (
    input  logic                            clock25MHz,
    input  logic                            reset,
    input  logic [9:0]                      x,
    input  logic [9:0]                      y,
    input  logic                            frame_start,
    input  logic                            btn_next,
    input  logic                            btn_prev,
    input  logic                            btn_mode,
    input  logic [12*NUM_PATTERNS-1:0]      pat_rgb,
    output logic [3:0]                      red,
    output logic [3:0]                      green,
    output logic [3:0]                      blue,
    output logic [$clog2(NUM_PATTERNS)-1:0] pattern_sel,
    output logic                            switch_pending,
    output logic                            auto_mode
);
    localparam int SEL_W = $clog2(NUM_PATTERNS);
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
`ifdef PATTERN_SEQUENCER_AUTO_CYCLE_EN
    localparam int NUM_BTN = 3;
`else
    localparam int NUM_BTN = 2;
`endif

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] sync1_q, sync2_q, level_q, press_q;
    logic [CNT_W-1:0]   cnt_q [NUM_BTN];

    state_t             state_q, state_d;
    logic               dir_next_q, dir_next_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [11:0]        pix_q, pix_d;
    logic               press_one;

    // Bit 0 = next, bit 1 = prev, bit 2 = mode (auto build only).
`ifdef PATTERN_SEQUENCER_AUTO_CYCLE_EN
    assign btn_raw = {btn_mode, btn_prev, btn_next};
`else
    logic unused_btn_mode;
    assign btn_raw         = {btn_prev, btn_next};
    assign unused_btn_mode = btn_mode;
`endif

    always_ff @(posedge clock25MHz or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            level_q <= '0;
            press_q <= '0;
            for (int i = 0; i < NUM_BTN; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            for (int i = 0; i < NUM_BTN; i++) begin
                press_q[i] <= 1'b0;
                if (sync2_q[i] == level_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    level_q[i] <= sync2_q[i];
                    press_q[i] <= sync2_q[i];
                    cnt_q[i]   <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    function automatic logic [SEL_W-1:0] sel_inc(input logic [SEL_W-1:0] s);
        return (s == SEL_W'(NUM_PATTERNS - 1)) ? '0 : s + 1'b1;
    endfunction

    function automatic logic [SEL_W-1:0] sel_dec(input logic [SEL_W-1:0] s);
        return (s == '0) ? SEL_W'(NUM_PATTERNS - 1) : s - 1'b1;
    endfunction

    // Next and prev in the same cycle cancel out.
    assign press_one = press_q[0] ^ press_q[1];

`ifdef PATTERN_SEQUENCER_AUTO_CYCLE_EN
    localparam int FCNT_W = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;
    logic              auto_q, auto_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;

    always_ff @(posedge clock25MHz or negedge reset) begin
        if (!reset) begin
            auto_q <= 1'b0;
            fcnt_q <= '0;
        end else begin
            auto_q <= auto_d;
            fcnt_q <= fcnt_d;
        end
    end

    assign auto_mode = auto_q;
`else
    assign auto_mode = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        dir_next_d = dir_next_q;
        sel_d      = sel_q;
`ifdef PATTERN_SEQUENCER_AUTO_CYCLE_EN
        auto_d     = auto_q;
        fcnt_d     = fcnt_q;
`endif
        if (frame_start && state_q == PENDING) begin
            sel_d   = dir_next_q ? sel_inc(sel_q) : sel_dec(sel_q);
            state_d = IDLE;
        end
        // A press on the commit cycle re-arms PENDING and waits for the following frame.
        if (press_one) begin
            dir_next_d = press_q[0];
            state_d    = PENDING;
        end
`ifdef PATTERN_SEQUENCER_AUTO_CYCLE_EN
        if (auto_q && frame_start) begin
            if (state_q == PENDING) begin
                fcnt_d = '0;
            end else if (fcnt_q == FCNT_W'(AUTO_FRAMES - 1)) begin
                sel_d  = sel_inc(sel_q);
                fcnt_d = '0;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
        if (press_q[2]) begin
            auto_d = !auto_q;
            if (auto_q) fcnt_d = '0;
        end
`endif
    end

    always_comb begin
        pix_d = '0;
        if (x < 10'(H_ACTIVE) && y < 10'(V_ACTIVE)) begin
            for (int k = 0; k < NUM_PATTERNS; k++) begin
                if (sel_q == SEL_W'(k)) pix_d = pat_rgb[12*k +: 12];
            end
        end
    end

    always_ff @(posedge clock25MHz or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            dir_next_q <= 1'b0;
            sel_q      <= '0;
            pix_q      <= '0;
        end else begin
            state_q    <= state_d;
            dir_next_q <= dir_next_d;
            sel_q      <= sel_d;
            pix_q      <= pix_d;
        end
    end

    // switch_pending is the FSM state itself, so it doubles as the state debug view.
    assign switch_pending       = (state_q == PENDING);
    assign pattern_sel          = sel_q;
    assign {red, green, blue}   = pix_q;

endmodule

// File: tb/tb_pattern_sequencer.sv
// Self-checking bench for pattern_sequencer: directed button/frame stimulus, a window-based
// behavioural model compared every cycle, and literal checkpoints.
module tb_pattern_sequencer;
    localparam int N  = 4;
    localparam int D  = 8;
    localparam int AF = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [9:0]      x, y;
    logic            fs, bn, bp, bm;
    logic [12*N-1:0] pat;
    logic [3:0]      red, green, blue;
    logic [1:0]      pattern_sel;
    logic            switch_pending, auto_mode;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pattern_sequencer #(
        .NUM_PATTERNS(N), .DEBOUNCE_CYCLES(D), .AUTO_FRAMES(AF), .H_ACTIVE(640), .V_ACTIVE(480)
    ) dut (
        .clock25MHz(clk), .reset(rst_n), .x(x), .y(y), .frame_start(fs),
        .btn_next(bn), .btn_prev(bp), .btn_mode(bm), .pat_rgb(pat),
        .red(red), .green(green), .blue(blue), .pattern_sel(pattern_sel),
        .switch_pending(switch_pending), .auto_mode(auto_mode)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: button histories (bit k = raw level k edges ago), debounced levels, press flags.
    logic [D+1:0] h_n = '0, h_p = '0, h_m = '0;
    bit           lv_n, lv_p, lv_m, pr_n, pr_p, pr_m;
    bit           m_pending, m_dir, m_auto;
    int           m_sel, m_frames;
    logic [11:0]  m_rgb = '0;

    // A level is accepted once the synchronised input has shown it for D consecutive edges.
    task automatic settle(input logic [D+1:0] h, inout bit lv, output bit pr);
        pr = 1'b0;
        if (h[D+1:2] == {D{~lv}}) begin
            lv = ~lv;
            pr = lv;
        end
    endtask

    task automatic model_reset();
        h_n = '0; h_p = '0; h_m = '0;
        lv_n = 0; lv_p = 0; lv_m = 0; pr_n = 0; pr_p = 0; pr_m = 0;
        m_pending = 0; m_dir = 0; m_auto = 0; m_sel = 0; m_frames = 0; m_rgb = '0;
    endtask

    task automatic model_step();
        bit was_pending;
        was_pending = m_pending;
        m_rgb = (x < 10'd640 && y < 10'd480) ? 12'(12'h111 * (m_sel + 1)) : 12'h000;
        if (fs && was_pending) begin
            m_sel     = m_dir ? (m_sel + 1) % N : (m_sel + N - 1) % N;
            m_pending = 0;
        end
        if (pr_n != pr_p) begin
            m_dir     = pr_n;
            m_pending = 1;
        end
`ifdef PATTERN_SEQUENCER_AUTO_CYCLE_EN
        if (m_auto && fs) begin
            if (was_pending) m_frames = 0;
            else begin
                m_frames++;
                if (m_frames == AF) begin
                    m_sel    = (m_sel + 1) % N;
                    m_frames = 0;
                end
            end
        end
        if (pr_m) begin
            m_auto   = !m_auto;
            m_frames = 0;
        end
`endif
        h_n = {h_n[D:0], bn};
        h_p = {h_p[D:0], bp};
        h_m = {h_m[D:0], bm};
        settle(h_n, lv_n, pr_n);
        settle(h_p, lv_p, pr_p);
        settle(h_m, lv_m, pr_m);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else model_step();
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_rgb", 32'({red, green, blue}), 32'h0);
            check("rst_sel", 32'(pattern_sel), 32'h0);
            check("rst_pending", 32'(switch_pending), 32'h0);
            check("rst_auto", 32'(auto_mode), 32'h0);
        end else begin
            check("rgb", 32'({red, green, blue}), 32'(m_rgb));
            check("sel", 32'(pattern_sel), 32'(m_sel));
            check("pending", 32'(switch_pending), 32'(m_pending));
            check("auto", 32'(auto_mode), 32'(m_auto));
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_fs();
        fs = 1'b1;
        step(1);
        fs = 1'b0;
        step(3);
    endtask

    // which: 0 next, 1 prev, 2 both, 3 mode; on_fs lands frame_start on the press-pulse cycle.
    task automatic press(input int which, input bit on_fs);
        case (which)
            0: bn = 1'b1;
            1: bp = 1'b1;
            2: begin bn = 1'b1; bp = 1'b1; end
            default: bm = 1'b1;
        endcase
        step(D + 2);
        if (on_fs) fs = 1'b1;
        step(1);
        fs = 1'b0;
        step(2);
        bn = 1'b0; bp = 1'b0; bm = 1'b0;
        step(D + 4);
    endtask

    task automatic async_reset_check();
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_rgb", 32'({red, green, blue}), 32'h0);
        check("async_rst_sel", 32'(pattern_sel), 32'h0);
        check("async_rst_pending", 32'(switch_pending), 32'h0);
        check("async_rst_auto", 32'(auto_mode), 32'h0);
        step(2);
        rst_n = 1'b1;
        step(2);
        check("post_rst_rgb", 32'({red, green, blue}), 32'h111);
    endtask

    initial begin
        rst_n = 1'b0;
        x = 10'd10; y = 10'd10;
        fs = 1'b0; bn = 1'b0; bp = 1'b0; bm = 1'b0;
        for (int k = 0; k < N; k++) pat[12*k +: 12] = 12'(12'h111 * (k + 1));
        step(3);
        rst_n = 1'b1;
        step(1);
        check("first_pixel", 32'({red, green, blue}), 32'h111);
        check("first_sel", 32'(pattern_sel), 32'h0);

        x = 10'd639; step(1); check("x639_visible", 32'({red, green, blue}), 32'h111);
        x = 10'd640; step(1); check("x640_blank", 32'({red, green, blue}), 32'h0);
        x = 10'd700; step(1); check("x700_blank", 32'({red, green, blue}), 32'h0);
        x = 10'd10; y = 10'd479; step(1); check("y479_visible", 32'({red, green, blue}), 32'h111);
        y = 10'd480; step(1); check("y480_blank", 32'({red, green, blue}), 32'h0);
        y = 10'd10; step(1);

        bn = 1'b1;
        step(D + 2);
        check("pending_before_latency", 32'(switch_pending), 32'h0);
        step(1);
        check("pending_after_latency", 32'(switch_pending), 32'h1);
        step(2);
        bn = 1'b0;
        step(D + 4);
        check("sel_held_midframe", 32'(pattern_sel), 32'h0);
        fs = 1'b1; step(1); fs = 1'b0;
        check("sel_commit", 32'(pattern_sel), 32'h1);
        check("pending_cleared", 32'(switch_pending), 32'h0);
        check("rgb_commit_edge", 32'({red, green, blue}), 32'h111);
        step(1);
        check("rgb_new_pattern", 32'({red, green, blue}), 32'h222);

        for (int g = 0; g < 3; g++) begin
            bn = 1'b1; step(D - 1);
            bn = 1'b0; step(4);
        end
        step(D + 4);
        pulse_fs();
        pulse_fs();
        check("glitch_sel", 32'(pattern_sel), 32'h1);

        press(1, 1'b0); pulse_fs();
        check("prev_to_0", 32'(pattern_sel), 32'h0);
        press(1, 1'b1);
        check("press_on_fs_held", 32'(pattern_sel), 32'h0);
        check("press_on_fs_pending", 32'(switch_pending), 32'h1);
        pulse_fs();
        check("prev_wrap", 32'(pattern_sel), 32'h3);

        press(0, 1'b0); press(1, 1'b0);
        check("latest_pending", 32'(switch_pending), 32'h1);
        pulse_fs();
        check("latest_wins", 32'(pattern_sel), 32'h2);

        press(2, 1'b0);
        check("cancel_pending", 32'(switch_pending), 32'h0);
        pulse_fs();
        check("cancel_sel", 32'(pattern_sel), 32'h2);

        press(0, 1'b0);
        check("pre_reset_pending", 32'(switch_pending), 32'h1);
        async_reset_check();

`ifdef PATTERN_SEQUENCER_AUTO_CYCLE_EN
        press(3, 1'b0);
        check("auto_on", 32'(auto_mode), 32'h1);
        pulse_fs(); pulse_fs();
        check("auto_wait", 32'(pattern_sel), 32'h0);
        pulse_fs();
        check("auto_adv1", 32'(pattern_sel), 32'h1);
        pulse_fs(); pulse_fs(); pulse_fs();
        check("auto_adv2", 32'(pattern_sel), 32'h2);
        async_reset_check();
`endif

        step(4);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
